// File: rtl/fifo_buf_ctrl.sv
// Synchronous show-ahead FIFO controller with registered occupancy flags.
// Define FIFO_BUF_CTRL_ERR_EN to add sticky overflow/underflow flags and err_clr.
module fifo_buf_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_LEVEL   = 14,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] w_data,
`ifdef FIFO_BUF_CTRL_ERR_EN
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AfCnt    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AeCnt    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  ae_q, ae_d;
    logic                  af_q, af_d;
    logic                  wr_accept, rd_accept;

    // A read frees a slot in the same edge, so a full FIFO still takes a paired write.
    assign wr_accept = wr && (!full_q || rd);
    assign rd_accept = rd && !empty_q;

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        if (wr_accept) w_ptr_d = w_ptr_q + 1'b1;
        if (rd_accept) r_ptr_d = r_ptr_q + 1'b1;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Flags are derived from the next count so they never lag the count register.
        empty_d = (count_d == '0);
        full_d  = (count_d == DepthCnt);
        ae_d    = (count_d <= AeCnt);
        af_d    = (count_d >= AfCnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ae_q    <= ae_d;
            af_q    <= af_d;
        end
    end

    // Storage is never cleared; reset only drops the in-flight write.
    always_ff @(posedge clk) begin
        if (!reset && wr_accept) begin
            mem_q[w_ptr_q] <= w_data;
        end
    end

    assign r_data       = mem_q[r_ptr_q];
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign count        = count_q;

`ifdef FIFO_BUF_CTRL_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (wr && full_q && !rd);
        underflow_d = underflow_q || (rd && empty_q);
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_buf_ctrl.sv
// Scoreboard bench for fifo_buf_ctrl: a queue-based model predicts each cycle's state,
// a monitor compares it against the DUT on the falling edge.
module tb_fifo_buf_ctrl;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       reset, wr, rd;
    logic [7:0] w_data, r_data;
    logic       empty, full, almost_empty, almost_full;
    logic [4:0] count;
    logic       err_clr;
`ifdef FIFO_BUF_CTRL_ERR_EN
    logic       overflow, underflow;
`endif

    always #5 clk = ~clk;

    fifo_buf_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .rd          (rd),
        .w_data      (w_data),
`ifdef FIFO_BUF_CTRL_ERR_EN
        .err_clr     (err_clr),
        .overflow    (overflow),
        .underflow   (underflow),
`endif
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count)
    );

    typedef struct {
        int cnt;
        bit emp;
        bit ful;
        bit ae;
        bit af;
        bit hv;
        int head;
        bit ov;
        bit un;
    } exp_t;

    exp_t exp_q[$];
    int   model[$];
    bit   m_ov, m_un;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge state, queue it after the edge.
    task automatic step(input bit rst, input bit w, input bit r, input int d, input bit clr);
        exp_t e;
        bit   do_w, do_r, was_full, was_empty;
        reset   = rst;
        wr      = w;
        rd      = r;
        w_data  = d[7:0];
        err_clr = clr;
        if (rst) begin
            model.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            was_full  = (model.size() == DEPTH);
            was_empty = (model.size() == 0);
            do_r = r && !was_empty;
            do_w = w && (!was_full || r);
            if (clr) begin
                m_ov = 1'b0;
                m_un = 1'b0;
            end else begin
                if (w && was_full && !r) m_ov = 1'b1;
                if (r && was_empty) m_un = 1'b1;
            end
            if (do_r) void'(model.pop_front());
            if (do_w) model.push_back(d & 'hff);
        end
        e.cnt  = model.size();
        e.emp  = (e.cnt == 0);
        e.ful  = (e.cnt == DEPTH);
        e.ae   = (e.cnt <= AE);
        e.af   = (e.cnt >= AF);
        e.hv   = (e.cnt > 0);
        e.head = e.hv ? model[0] : 0;
        e.ov   = m_ov;
        e.un   = m_un;
        @(posedge clk);
        exp_q.push_back(e);
        #2;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("count", int'(count), e.cnt);
                check("empty", int'(empty), int'(e.emp));
                check("full", int'(full), int'(e.ful));
                check("almost_empty", int'(almost_empty), int'(e.ae));
                check("almost_full", int'(almost_full), int'(e.af));
                if (e.hv) check("r_data", int'(r_data), e.head);
`ifdef FIFO_BUF_CTRL_ERR_EN
                check("overflow", int'(overflow), int'(e.ov));
                check("underflow", int'(underflow), int'(e.un));
`endif
            end
        end
    end

    initial begin
        reset   = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        w_data  = '0;
        err_clr = 1'b0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Fill with 0x00..0x0F, then drain in order.
        for (int i = 0; i < 16; i++) step(0, 1, 0, i, 0);
        // Write on full without read must be dropped.
        step(0, 1, 0, 'h77, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
        // Read on empty must be dropped.
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // Simultaneous wr/rd on empty: only the write lands.
        step(0, 1, 1, 'hA5, 0);
        step(0, 0, 1, 0, 0);

        // Simultaneous wr/rd on full across pointer wrap.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 'h40 + i, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 'h80 + i, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);

        // Reset with 7 entries and a pending write.
        for (int i = 0; i < 7; i++) step(0, 1, 0, 'h30 + i, 0);
        step(1, 1, 0, 'h99, 0);
        step(0, 0, 0, 0, 0);

        // Sticky error flags and clear priority over a same-cycle set.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 'h60 + i, 0);
        step(0, 1, 0, 'hEE, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 'hEF, 1);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // Randomized traffic with phases biased toward full, empty and balanced.
        for (int i = 0; i < 900; i++) begin
            int mode;
            int wp, rp;
            mode = (i / 100) % 3;
            wp = (mode == 0) ? 80 : (mode == 1) ? 25 : 55;
            rp = (mode == 0) ? 25 : (mode == 1) ? 80 : 55;
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < wp,
                 $urandom_range(0, 99) < rp,
                 int'($urandom_range(0, 255)),
                 $urandom_range(0, 19) == 0);
        end

        reset = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_buf_ctrl.md
FIFO_BUF_CTRL -- requirements
Module: fifo_buf_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, width of stored words.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, giving depth DEPTH = 2**ADDR_WIDTH entries.
REQ-003 The block SHALL have parameter AF_LEVEL, default 14, almost-full threshold (1..DEPTH).
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, almost-empty threshold (0..DEPTH-1).
REQ-005 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 The block SHALL have port wr  input  1  write request.
REQ-008 The block SHALL have port rd  input  1  read (pop) request.
REQ-009 The block SHALL have port w_data  input  DATA_WIDTH  write data.
REQ-010 The block SHALL have port r_data  output  DATA_WIDTH  head-of-queue word.
REQ-011 The block SHALL have port empty  output  1  no entries held.
REQ-012 The block SHALL have port full  output  1  DEPTH entries held.
REQ-013 The block SHALL have port almost_empty  output  1  count <= AE_LEVEL.
REQ-014 The block SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-015 The block SHALL have port count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-016 The block SHALL have ports err_clr input 1, overflow output 1, underflow output 1, present only per REQ-030.

Function
REQ-017 The block SHALL contain DEPTH x DATA_WIDTH storage plus ADDR_WIDTH-bit write and read pointers wrapping DEPTH-1 -> 0.
REQ-018 Accepted write: mem[w_ptr] <= w_data, w_ptr +1 at the same edge; write accepted iff wr && (!full || rd).
REQ-019 Accepted read: r_ptr +1; read accepted iff rd && !empty.
REQ-020 r_data SHALL be combinational mem[r_ptr] (show-ahead, zero latency); value undefined-but-stable when empty.
REQ-021 wr && rd while empty: write only accepted, count 0 -> 1, empty deasserts next cycle, r_ptr unchanged.
REQ-022 wr && rd while full: both accepted, both pointers advance, count stays DEPTH, full stays asserted.
REQ-023 wr && rd otherwise: both accepted, count unchanged.
REQ-024 count SHALL be registered: +1 on write-only, -1 on read-only, unchanged otherwise; never exceeds DEPTH or goes below 0.
REQ-025 empty, full, almost_empty, almost_full SHALL be registered and consistent with count in the same cycle (no lag).
REQ-026 wr while full without rd, and rd while empty, SHALL be ignored: no pointer, count or storage change.

Reset
REQ-027 reset sampled high at a clk edge SHALL set w_ptr=0, r_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (overflow=0, underflow=0 when present).
REQ-028 reset SHALL take priority over wr/rd in the same cycle; in-flight requests are discarded.
REQ-029 Storage contents SHALL NOT be reset.

Configuration
REQ-030 With macro FIFO_BUF_CTRL_ERR_EN defined: overflow sets on wr && full && !rd, underflow sets on rd && empty; both sticky until err_clr=1 (clear wins over a same-cycle set) or reset; without it: err_clr, overflow, underflow ports and logic are absent, REQ-026 cases remain silently ignored.

Verification
REQ-031 Reset, then 16 writes 0x00..0x0F, no reads -> count=16, full=1, almost_full=1 from 14th write on, r_data=0x00.
REQ-032 From full, 16 reads -> r_data sequence 0x00..0x0F, empty=1 after 16th, almost_empty=1 when count<=2.
REQ-033 From empty, wr=rd=1 with w_data=0xA5 -> next cycle count=1, empty=0, r_data=0xA5.
REQ-034 From full, wr=rd=1 for 20 cycles with incrementing data -> full stays 1, count=16, pointers wrap, read order preserved.
REQ-035 With FIFO_BUF_CTRL_ERR_EN: wr on full (rd=0) -> overflow=1, count=16, contents unchanged; then err_clr=1 -> overflow=0 next cycle.
REQ-036 Reset asserted with count=7 and wr=1 -> next cycle count=0, empty=1, write discarded.
